// File: rtl/hc_sr04_pkg.sv
// Shared types and defaults for the HC-SR04 round-robin scan scheduler.
// Default timing constants assume a 50 MHz system clock.
package hc_sr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_GAP       = 3'd4
  } scan_state_t;

  localparam int unsigned DEF_NUM_SENSORS    = 4;
  localparam int unsigned DEF_IDX_W          = 2;
  localparam int unsigned DEF_TRIG_CYCLES    = 500;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_900_000;
  localparam int unsigned DEF_GAP_CYCLES     = 3_000_000;
  localparam int unsigned DEF_RANGE_W        = 32;

  // Sentinel published as range_data when a sample times out (truncated to RANGE_W).
  localparam logic [63:0] RANGE_ALL_ONES = '1;

endpackage

// File: rtl/hc_sr04_echo_sync.sv
// Two-flop synchronizer for asynchronous echo pins plus edge strobes
// derived from the synchronized level and its one-cycle delayed copy.
module hc_sr04_echo_sync
  import hc_sr04_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_NUM_SENSORS
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_echo,
  output logic [WIDTH-1:0] o_rise_c,
  output logic [WIDTH-1:0] o_fall_c
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_sync_d;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_meta   <= i_echo;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise_c = r_sync & ~r_sync_d;
  assign o_fall_c = ~r_sync & r_sync_d;

endmodule

// File: rtl/hc_sr04_scan_scheduler.sv
// Round-robin HC-SR04 scheduler: fires one sensor at a time, measures its
// echo width in clocks with a timeout, publishes a tagged sample, then waits a gap.
module hc_sr04_scan_scheduler
  import hc_sr04_pkg::*;
#(
  parameter int unsigned NUM_SENSORS    = DEF_NUM_SENSORS,
  parameter int unsigned IDX_W          = DEF_IDX_W,
  parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned RANGE_W        = DEF_RANGE_W
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  output logic [NUM_SENSORS-1:0] o_trigger,
  input  logic [NUM_SENSORS-1:0] i_echo,
  output logic [RANGE_W-1:0]     o_range_data,
  output logic [IDX_W-1:0]       o_range_idx,
  output logic                   o_range_valid,
  output logic                   o_range_timeout,
  output logic                   o_busy,
  output logic                   o_scan_done
);

  localparam logic [RANGE_W-1:0] TRIG_LAST    = RANGE_W'(TRIG_CYCLES - 1);
  localparam logic [RANGE_W-1:0] WAIT_LAST    = RANGE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RANGE_W-1:0] MEAS_LIMIT   = RANGE_W'(TIMEOUT_CYCLES);
  localparam logic [RANGE_W-1:0] GAP_LAST     = RANGE_W'(GAP_CYCLES - 1);
  localparam logic [RANGE_W-1:0] SENTINEL     = RANGE_W'(RANGE_ALL_ONES);
  localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(NUM_SENSORS - 1);

  scan_state_t            r_state;
  scan_state_t            w_state_nxt;
  logic [RANGE_W-1:0]     r_cnt;
  logic [RANGE_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_SENSORS-1:0] r_trigger;
  logic [NUM_SENSORS-1:0] w_trigger_nxt;
  logic [RANGE_W-1:0]     r_range_data;
  logic [RANGE_W-1:0]     w_range_data_nxt;
  logic [IDX_W-1:0]       r_range_idx;
  logic [IDX_W-1:0]       w_range_idx_nxt;
  logic                   r_range_timeout;
  logic                   w_range_timeout_nxt;
  logic                   r_range_valid;
  logic                   r_scan_done;
  logic                   r_busy;
  logic                   w_emit;
  logic                   w_emit_to;
  logic [NUM_SENSORS-1:0] w_rise_c;
  logic [NUM_SENSORS-1:0] w_fall_c;

  hc_sr04_echo_sync #(
    .WIDTH (NUM_SENSORS)
  ) u_echo_sync (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_echo    (i_echo),
    .o_rise_c  (w_rise_c),
    .o_fall_c  (w_fall_c)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_trigger       <= '0;
      r_range_data    <= '0;
      r_range_idx     <= '0;
      r_range_timeout <= 1'b0;
      r_range_valid   <= 1'b0;
      r_scan_done     <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_idx           <= w_idx_nxt;
      r_trigger       <= w_trigger_nxt;
      r_range_data    <= w_range_data_nxt;
      r_range_idx     <= w_range_idx_nxt;
      r_range_timeout <= w_range_timeout_nxt;
      r_range_valid   <= w_emit;
      r_scan_done     <= w_emit && (r_idx == LAST_IDX);
      r_busy          <= (w_state_nxt != ST_IDLE);
    end
  end

  // Next-state, counter and sample logic; outputs are registered from next-state values.
  always_comb begin
    w_state_nxt         = r_state;
    w_cnt_nxt           = r_cnt;
    w_idx_nxt           = r_idx;
    w_emit              = 1'b0;
    w_emit_to           = 1'b0;
    w_trigger_nxt       = '0;
    w_range_data_nxt    = r_range_data;
    w_range_idx_nxt     = r_range_idx;
    w_range_timeout_nxt = r_range_timeout;

    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_TRIG;
          w_cnt_nxt   = '0;
        end
      end
      ST_TRIG: begin
        if (r_cnt == TRIG_LAST) begin
          w_state_nxt = ST_WAIT_RISE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + RANGE_W'(1);
        end
      end
      // Only a clean 0->1 edge counts; a level already high on entry is ignored.
      ST_WAIT_RISE: begin
        if (w_rise_c[r_idx]) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = RANGE_W'(1);
        end else if (r_cnt == WAIT_LAST) begin
          w_emit      = 1'b1;
          w_emit_to   = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + RANGE_W'(1);
        end
      end
      ST_MEASURE: begin
        if (w_fall_c[r_idx]) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= MEAS_LIMIT) begin
          w_emit      = 1'b1;
          w_emit_to   = 1'b1;
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + RANGE_W'(1);
        end
      end
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_idx_nxt   = (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
          w_state_nxt = i_enable ? ST_TRIG : ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + RANGE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_emit) begin
      w_range_data_nxt    = w_emit_to ? SENTINEL : r_cnt;
      w_range_idx_nxt     = r_idx;
      w_range_timeout_nxt = w_emit_to;
    end

    if (w_state_nxt == ST_TRIG) begin
      w_trigger_nxt = NUM_SENSORS'(1) << w_idx_nxt;
    end
  end

  assign o_trigger       = r_trigger;
  assign o_range_data    = r_range_data;
  assign o_range_idx     = r_range_idx;
  assign o_range_valid   = r_range_valid;
  assign o_range_timeout = r_range_timeout;
  assign o_busy          = r_busy;
  assign o_scan_done     = r_scan_done;

endmodule

// File: tb/tb_hc_sr04_scan_scheduler.sv
// Self-checking bench for hc_sr04_scan_scheduler: directed ping table, randomized
// pings against an arithmetic latency model, and reset / enable-drop sequences.
module tb_hc_sr04_scan_scheduler;

  localparam int unsigned NS = 3;
  localparam int unsigned IW = 2;
  localparam int unsigned TC = 5;
  localparam int unsigned TO = 100;
  localparam int unsigned GC = 20;
  localparam int unsigned RW = 32;
  localparam logic [RW-1:0] ONES = '1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NS-1:0] echo;
  logic [NS-1:0] trigger;
  logic [RW-1:0] range_data;
  logic [IW-1:0] range_idx;
  logic          range_valid;
  logic          range_timeout;
  logic          busy;
  logic          scan_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;

  always #5 clock = ~clock;

  hc_sr04_scan_scheduler #(
    .NUM_SENSORS    (NS),
    .IDX_W          (IW),
    .TRIG_CYCLES    (TC),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GC),
    .RANGE_W        (RW)
  ) dut (
    .i_clock         (clock),
    .i_reset_n       (reset_n),
    .i_enable        (enable),
    .o_trigger       (trigger),
    .i_echo          (echo),
    .o_range_data    (range_data),
    .o_range_idx     (range_idx),
    .o_range_valid   (range_valid),
    .o_range_timeout (range_timeout),
    .o_busy          (busy),
    .o_scan_done     (scan_done)
  );

  // d: clocks after trigger falls before echo rises; w: echo pin high width.
  // pre: echo already high through the trigger pulse; drop_en: enable drops mid-trigger.
  typedef struct {
    int            d;
    int            w;
    bit            drive;
    bit            pre;
    bit            drop_en;
    int            exp_lat;
    logic [RW-1:0] exp_data;
    bit            exp_to;
  } ping_t;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (sensor %0d, t=%0t)", name, act, exp, exp_idx, $time);
    end
  endtask

  function automatic ping_t mk(input int d, input int w, input bit drive, input bit pre,
                               input int lat, input logic [RW-1:0] data, input bit to);
    ping_t p;
    p.d = d; p.w = w; p.drive = drive; p.pre = pre; p.drop_en = 1'b0;
    p.exp_lat = lat; p.exp_data = data; p.exp_to = to;
    return p;
  endfunction

  // Reference: the echo is seen 3 clocks after the pin moves; the rise must land
  // inside the TO-clock wait window and the measured width may not exceed TO.
  function automatic ping_t model(input int d, input int w, input bit drive, input bit pre);
    ping_t p;
    p = mk(d, w, drive, pre, 0, '0, 1'b0);
    if (!drive || pre || (d + 2 > int'(TO) - 1)) begin
      p.exp_lat = int'(TO); p.exp_data = ONES; p.exp_to = 1'b1;
    end else if (w > int'(TO)) begin
      p.exp_lat = d + int'(TO) + 3; p.exp_data = ONES; p.exp_to = 1'b1;
    end else begin
      p.exp_lat = d + w + 3; p.exp_data = RW'(w); p.exp_to = 1'b0;
    end
    return p;
  endfunction

  function automatic logic sel_level(input ping_t p, input int k);
    if (p.pre) return (k < p.w);
    return p.drive && (k >= p.d) && (k < p.d + p.w);
  endfunction

  task automatic do_ping(input ping_t p, input bit exp_stop);
    logic [NS-1:0] oh;
    int n;
    int kv;
    int g;
    int extra;
    oh = NS'(1) << exp_idx;
    n = 0;
    while (trigger == '0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("trigger_onehot", RW'(trigger), RW'(oh));
    echo = p.pre ? oh : '0;
    n = 0;
    while (trigger != '0 && n < 50) begin
      n++;
      if (p.drop_en && n == 2) enable = 1'b0;
      @(negedge clock);
    end
    chk("trigger_width", RW'(n), RW'(TC));
    kv = -1;
    for (int k = 0; k < 400; k++) begin
      if (range_valid) begin
        kv = k;
        break;
      end
      echo = NS'($urandom) & ~oh;
      if (sel_level(p, k)) echo = echo | oh;
      @(negedge clock);
    end
    chk("sample_latency", RW'(kv), RW'(p.exp_lat));
    if (kv < 0) begin
      exp_idx = (exp_idx + 1) % int'(NS);
      return;
    end
    chk("range_data", range_data, p.exp_data);
    chk("range_idx", RW'(range_idx), RW'(exp_idx));
    chk("range_timeout", RW'(range_timeout), RW'(p.exp_to));
    chk("scan_done", RW'(scan_done), RW'(exp_idx == int'(NS) - 1));
    g = 0;
    extra = 0;
    while (g < 60) begin
      echo = NS'($urandom) & ~oh;
      if (sel_level(p, kv + g)) echo = echo | oh;
      @(negedge clock);
      g++;
      if (range_valid) extra++;
      if (trigger != '0 || !busy) break;
    end
    chk("gap_length", RW'(g), RW'(GC));
    chk("gap_extra_sample", RW'(extra), RW'(0));
    if (exp_stop) chk("idle_after_gap_busy", RW'(busy), RW'(0));
    else          chk("next_trigger_after_gap", RW'(trigger != '0), RW'(1));
    exp_idx = (exp_idx + 1) % int'(NS);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_trigger"}, RW'(trigger), '0);
    chk({tag, "_range_data"}, range_data, '0);
    chk({tag, "_range_idx"}, RW'(range_idx), '0);
    chk({tag, "_range_valid"}, RW'(range_valid), '0);
    chk({tag, "_range_timeout"}, RW'(range_timeout), '0);
    chk({tag, "_busy"}, RW'(busy), '0);
    chk({tag, "_scan_done"}, RW'(scan_done), '0);
  endtask

  ping_t tbl [12];
  ping_t p;
  int    n;

  initial begin
    tbl[0]  = mk(10,  40, 1, 0,  53,   40, 0);
    tbl[1]  = mk( 5,  20, 1, 0,  28,   20, 0);
    tbl[2]  = mk( 5,  30, 1, 0,  38,   30, 0);
    tbl[3]  = mk( 3,  10, 1, 0,  16,   10, 0);
    tbl[4]  = mk( 0,   0, 0, 0, 100, ONES, 1);
    tbl[5]  = mk( 0,   1, 1, 0,   4,    1, 0);
    tbl[6]  = mk(10, 500, 1, 0, 113, ONES, 1);
    tbl[7]  = mk(97,   2, 1, 0, 102,    2, 0);
    tbl[8]  = mk(98,   5, 1, 0, 100, ONES, 1);
    tbl[9]  = mk( 0, 300, 1, 1, 100, ONES, 1);
    tbl[10] = mk( 0, 100, 1, 0, 103,  100, 0);
    tbl[11] = mk( 0, 101, 1, 0, 103, ONES, 1);

    reset_n = 1'b0;
    enable  = 1'b0;
    echo    = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_values("por");
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle_disabled_busy", RW'(busy), '0);
    chk("idle_disabled_trigger", RW'(trigger), '0);

    enable = 1'b1;
    foreach (tbl[i]) do_ping(tbl[i], 1'b0);

    for (int i = 0; i < 15; i++) begin
      p = model(int'($urandom_range(0, 105)), int'($urandom_range(1, 125)),
                $urandom_range(0, 9) != 0, 1'b0);
      do_ping(p, 1'b0);
    end

    // Reset in the middle of a measurement.
    n = 0;
    while (trigger == '0 && n < 300) begin @(negedge clock); n++; end
    while (trigger != '0 && n < 300) begin @(negedge clock); n++; end
    echo = NS'(1) << exp_idx;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_values("mid_reset");
    echo    = '0;
    reset_n = 1'b1;
    exp_idx = 0;

    // Enable drops mid-trigger: the ping finishes, then the block parks in IDLE.
    p = model(5, 7, 1'b1, 1'b0);
    p.drop_en = 1'b1;
    do_ping(p, 1'b1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy || trigger != '0 || range_valid) n++;
    end
    chk("parked_idle_activity", RW'(n), '0);

    enable = 1'b1;
    do_ping(model(2, 15, 1'b1, 1'b0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hc_sr04_scan_scheduler.md
Name: hc_sr04_scan_scheduler

Overview:
Time-multiplexes N HC-SR04 ultrasonic sensors so only one fires at a time, which prevents acoustic crosstalk in multi-sensor radar builds.
It generates each sensor's trigger pulse and measures its echo width in clock cycles, with a timeout.
It publishes one tagged range sample per sensor, then enforces an inter-ping gap.
It sits between the top-level GPIO pins and the LED/bargraph or display logic, and replaces free-running 1 Hz trigger dividers.

Parameters:
NUM_SENSORS, 4, number of sensors scanned round-robin (1..16)
IDX_W, 2, width of sensor index; must satisfy 2**IDX_W >= NUM_SENSORS
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1_900_000, max wait for echo rise, and max echo width (38 ms)
GAP_CYCLES, 3_000_000, quiet time after each measurement before the next trigger (60 ms)
RANGE_W, 32, width of range counter/output

Ports:
clock  in  1  system clock (50 MHz on DE2)
reset_n  in  1  synchronous active-low reset
enable  in  1  scan runs while high; sampled only in IDLE and at end of GAP
trigger  out  NUM_SENSORS  one-hot trigger pins to sensors
echo  in  NUM_SENSORS  asynchronous echo pins from sensors
range_data  out  RANGE_W  echo width in clocks of latest sample
range_idx  out  IDX_W  sensor index of latest sample
range_valid  out  1  one-cycle strobe; range_data/range_idx/range_timeout valid
range_timeout  out  1  latest sample timed out (no echo, or echo too long)
busy  out  1  high in any state except IDLE
scan_done  out  1  one-cycle strobe coincident with range_valid of the last sensor (idx NUM_SENSORS-1)

Behaviour:
- Clocking and reset: all state updates on posedge clock. reset_n=0 at any edge, including mid-measurement, forces:
  - state=IDLE, trigger=0, range_data=0, range_idx=0, range_valid=0, range_timeout=0, busy=0, scan_done=0, cur_idx=0, counters=0, synchronizer flops=0.
- Echo input: each echo bit passes through a 2-FF synchronizer (echo_s). Rise/fall are detected from echo_s and its 1-cycle delayed copy.
- State machine:
  - IDLE: trigger=0. If enable=1, go to TRIG with cnt=0.
  - TRIG: trigger[cur_idx]=1, all other trigger bits 0, for exactly TRIG_CYCLES clocks. Then go to WAIT_RISE with cnt=0.
  - WAIT_RISE: trigger=0.
    - On echo_s[cur_idx] rise: go to MEASURE with cnt=1.
    - If cnt reaches TIMEOUT_CYCLES-1 with no rise: emit a sample with range_data = all ones and range_timeout=1, then go to GAP.
  - MEASURE: cnt increments each clock while echo_s[cur_idx]=1.
    - On fall: emit a sample with range_data = cnt (number of clocks echo_s was high) and range_timeout=0, then go to GAP.
    - If cnt reaches TIMEOUT_CYCLES while still high: emit a sample with range_data = all ones and range_timeout=1, then go to GAP. The remaining echo is ignored.
  - GAP: wait GAP_CYCLES clocks.
    - Then cur_idx = (cur_idx == NUM_SENSORS-1) ? 0 : cur_idx+1.
    - If enable=1, go to TRIG; otherwise go to IDLE.
- Sample emission:
  - range_data, range_idx=cur_idx and range_timeout register on the same clock that range_valid pulses, and hold until the next emission.
  - scan_done pulses in the same cycle when cur_idx == NUM_SENSORS-1.
- Echo gating: echo bits of non-selected sensors are ignored. A selected echo already high on entry to WAIT_RISE does not count as a rise; only a 0->1 edge does.
- enable deassertion: mid-scan the current sensor completes through GAP; no truncated trigger pulse is ever produced.
- Counter width: cnt is RANGE_W bits. TIMEOUT_CYCLES and GAP_CYCLES must be < 2**RANGE_W; the counter never wraps.
- busy = (state != IDLE).
- Latency: echo pin edge to internal detection is 3 clocks. range_valid asserts 3 clocks after the echo pin falls.

Decomposition:
- Package hc_sr04_pkg: state encoding localparams (IDLE, TRIG, WAIT_RISE, MEASURE, GAP), default timing constants for 50 MHz, and the RANGE_ALL_ONES sentinel.
- Sub-module hc_sr04_echo_sync: per-bit 2-FF synchronizer plus rise/fall strobes, instantiated NUM_SENSORS wide.
- The FSM and counters live in the top module.

Test Plan:
All scenarios use NUM_SENSORS=3, TRIG_CYCLES=5, TIMEOUT_CYCLES=100, GAP_CYCLES=20 unless stated.
1. Reset then enable=1, sensor 0 echo high for 40 clocks starting 10 clocks after trigger falls -> trigger[0] high exactly 5 clocks; range_valid with range_data=40, range_idx=0, range_timeout=0.
2. Full scan with echo widths 10, 20, 30 on sensors 0/1/2 -> three range_valid strobes with idx 0,1,2 and data 10,20,30; scan_done only with idx 2; next trigger is on trigger[0].
3. Sensor 1 never echoes -> 100 clocks after its trigger falls, range_valid with range_data=all ones, range_timeout=1, idx 1; scan proceeds to sensor 2.
4. Sensor 0 echo stuck high for 500 clocks -> sample at cnt=100 with all ones and timeout=1; the remaining high level is ignored; the next trigger goes to sensor 1 after 20 gap clocks.
5. Toggle echo[2] while sensor 0 is selected; hold echo[0] high before WAIT_RISE -> no false sample; the sensor-0 sample times out.
6. Assert reset_n=0 during MEASURE, then drop enable=0 mid-TRIG on the next run -> all outputs return to reset values, cur_idx=0; the trigger still completes 5 clocks, the sample is emitted, and the block returns to IDLE with busy=0 after GAP.
